// File: rtl/sega_pad_pkg.sv
// ---------------------------------------------------------------------------
// sega_pad_pkg
//   Shared constants for the Sega pad reader: user-port line indices, bit
//   positions inside the active-high joystick word, and the scan FSM states.
// ---------------------------------------------------------------------------
package sega_pad_pkg;

  // User-port line indices (pad pins as wired to the 7-bit port)
  localparam int DOWN  = 0;
  localparam int UP    = 1;
  localparam int TL    = 2;
  localparam int RIGHT = 3;
  localparam int TH    = 4;
  localparam int LEFT  = 5;
  localparam int TR    = 6;

  // Joystick word bit positions (1 = pressed)
  localparam int J_R = 0;
  localparam int J_L = 1;
  localparam int J_D = 2;
  localparam int J_U = 3;
  localparam int J_A = 4;
  localparam int J_B = 5;
  localparam int J_C = 6;
  localparam int J_S = 7;
  localparam int J_M = 8;
  localparam int J_X = 9;
  localparam int J_Y = 10;
  localparam int J_Z = 11;

  localparam int          JOY_W          = 12;
  localparam logic [6:0]  LINES_RELEASED = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

endpackage

// File: rtl/sega_pad_sync.sv
// ---------------------------------------------------------------------------
// sega_pad_sync
//   Two-flop synchroniser for the 7 pad lines. Resets to all-released so the
//   reader never sees a phantom press while coming out of reset.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   d        in   [6:0] raw user-port lines
//   q        out  [6:0] synchronised lines
// ---------------------------------------------------------------------------
module sega_pad_sync
  import sega_pad_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] d,
  output logic [6:0] q
);

  logic [6:0] meta;

  // NOTE: non-blocking assignments make both stages capture pre-edge values,
  // giving a true two-stage pipeline regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= LINES_RELEASED;
      q    <= LINES_RELEASED;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sega_pad_reader.sv
// ---------------------------------------------------------------------------
// sega_pad_reader
//   Scans one Sega 3/6-button pad on an open-drain user port by toggling TH
//   through eight phases, decodes the returned lines into an active-high
//   joystick word and publishes it atomically once per poll period.
// Ports:
//   clk       in   system clock (CLOCK_50 domain)
//   reset_n   in   asynchronous active-low reset
//   user_in   in   [6:0] pad lines (see sega_pad_pkg for indices)
//   user_out  out  [6:0] open-drain drive, 1 = release; only TH toggles
//   joy       out  [11:0] {Z,Y,X,M,S,C,B,A,U,D,L,R}, 1 = pressed
//   joy_valid out  one-cycle pulse when joy is updated
//   present   out  pad detected on last published scan
//   six_btn   out  6-button pad detected on last published scan
// Configuration:
//   SEGA_PAD_FILTER_EN  publish only when two consecutive scans agree
// ---------------------------------------------------------------------------
module sega_pad_reader
  import sega_pad_pkg::*;
#(
  parameter int PHASE_CYC = 500,
  parameter int POLL_CYC  = 100000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       user_in,
  output logic [6:0]       user_out,
  output logic [JOY_W-1:0] joy,
  output logic             joy_valid,
  output logic             present,
  output logic             six_btn
);

  localparam int PW = $clog2(PHASE_CYC);
  localparam int QW = $clog2(POLL_CYC);

  state_t            state, state_n;
  logic [QW-1:0]     poll_cnt;
  logic [PW-1:0]     phase_cnt;
  logic [2:0]        phase;
  logic [6:0]        line;
  logic [JOY_W-1:0]  scratch;
  logic              pres, six;
  logic              th, latch_en, update;
  logic              poll_wrap, phase_end, sample;
  logic              unused_th_readback;

  sega_pad_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (user_in),
    .q       (line)
  );

  // TH readback carries only our own drive, so it is deliberately ignored.
  assign unused_th_readback = line[TH];

  assign poll_wrap = (poll_cnt  == QW'(POLL_CYC - 1));
  assign phase_end = (phase_cnt == PW'(PHASE_CYC - 1));
  assign sample    = (state == ST_SCAN) && phase_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state;
    th       = 1'b1;
    latch_en = 1'b0;
    unique case (state)
      ST_IDLE:  if (poll_wrap) state_n = ST_SCAN;
      ST_SCAN: begin
        th = ~phase[0];
        if (phase_end && phase == 3'd7) state_n = ST_LATCH;
      end
      ST_LATCH: begin
        latch_en = 1'b1;
        state_n  = ST_IDLE;
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  // TH is decoded straight from reset-cleared flops, so asserting reset
  // releases the line in the same cycle.
  always_comb begin
    user_out     = LINES_RELEASED;
    user_out[TH] = th;
  end

  // Poll counter free-runs; phase counters run only during SCAN and are
  // back at zero by the time the next scan starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt  <= '0;
      phase_cnt <= '0;
      phase     <= '0;
    end else begin
      poll_cnt <= poll_wrap ? '0 : poll_cnt + QW'(1);
      if (state == ST_SCAN) begin
        if (phase_end) begin
          phase_cnt <= '0;
          phase     <= phase + 3'd1;
        end else begin
          phase_cnt <= phase_cnt + PW'(1);
        end
      end else begin
        phase_cnt <= '0;
        phase     <= '0;
      end
    end
  end

  // Decode in the last cycle of each phase, after the pad and the
  // synchroniser have settled. Every scratch bit is rewritten each scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= '0;
      pres    <= 1'b0;
      six     <= 1'b0;
    end else if (sample) begin
      unique case (phase)
        3'd0: begin
          scratch[J_U] <= ~line[UP];
          scratch[J_D] <= ~line[DOWN];
          scratch[J_L] <= ~line[LEFT];
          scratch[J_R] <= ~line[RIGHT];
          scratch[J_B] <= ~line[TL];
          scratch[J_C] <= ~line[TR];
        end
        3'd1: begin
          // A pad grounds Left/Right while TH is low; floating lines read 1.
          pres         <= ~line[LEFT] & ~line[RIGHT];
          scratch[J_A] <= ~line[TL];
          scratch[J_S] <= ~line[TR];
        end
        3'd5: six <= pres & ~line[UP] & ~line[DOWN];
        3'd6: begin
          scratch[J_Z] <= six & ~line[UP];
          scratch[J_Y] <= six & ~line[DOWN];
          scratch[J_X] <= six & ~line[LEFT];
          scratch[J_M] <= six & ~line[RIGHT];
        end
        default: ;
      endcase
    end
  end

`ifdef SEGA_PAD_FILTER_EN
  logic [JOY_W+1:0] prev_scan;
  logic             prev_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_scan <= '0;
      prev_ok   <= 1'b0;
    end else if (latch_en) begin
      prev_scan <= {pres, six, scratch};
      prev_ok   <= 1'b1;
    end
  end

  assign update = latch_en && prev_ok && (prev_scan == {pres, six, scratch});
`else
  assign update = latch_en;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joy       <= '0;
      joy_valid <= 1'b0;
      present   <= 1'b0;
      six_btn   <= 1'b0;
    end else begin
      joy_valid <= update;
      if (update) begin
        joy     <= pres ? scratch : '0;
        present <= pres;
        six_btn <= six;
      end
    end
  end

endmodule

// File: tb/tb_sega_pad_reader.sv
// ---------------------------------------------------------------------------
// tb_sega_pad_reader
//   Drives a behavioural Sega pad (none / 3-button / 6-button) that answers
//   the TH sequence, and compares every published scan with the word the pad
//   buttons should produce. Also checks TH timing, scan spacing, pulse width,
//   reset behaviour and the untouched user_out lines.
// ---------------------------------------------------------------------------
module tb_sega_pad_reader;

  localparam int P    = 8;
  localparam int POLL = 200;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  user_in;
  logic [6:0]  user_out;
  logic [11:0] joy;
  logic        joy_valid, present, six_btn;

  always #5 clk = ~clk;

  sega_pad_reader #(.PHASE_CYC(P), .POLL_CYC(POLL)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .user_in   (user_in),
    .user_out  (user_out),
    .joy       (joy),
    .joy_valid (joy_valid),
    .present   (present),
    .six_btn   (six_btn)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- pad model ----------------
  // kind: 0 = unplugged, 3 = 3-button, 6 = 6-button. btn uses the joy layout.
  int          pad_kind = 0;
  logic [11:0] btn      = '0;
  int          k        = 0;     // TH edges since pad's idle timeout
  int          hi_cnt   = 0;
  logic        last_th  = 1'b1;

  always @(posedge clk) begin
    if (user_out[4] != last_th) begin
      k      <= k + 1;
      hi_cnt <= 0;
    end else if (user_out[4]) begin
      if (hi_cnt >= 40) k <= 0;
      else              hi_cnt <= hi_cnt + 1;
    end
    last_th <= user_out[4];
  end

  function automatic logic [6:0] pad_pins(int kind, logic [11:0] b, int kk, logic th);
    logic [6:0] p;
    p    = 7'h7F;
    p[4] = th;
    if (kind == 0) return p;
    if (kk % 2 == 0) begin
      if (kind == 6 && kk == 6) begin
        p[1] = ~b[11]; p[0] = ~b[10]; p[5] = ~b[9]; p[3] = ~b[8];
      end else begin
        p[1] = ~b[3];  p[0] = ~b[2];  p[5] = ~b[1]; p[3] = ~b[0];
      end
      p[2] = ~b[5]; p[6] = ~b[6];
    end else begin
      if (kind == 6 && kk == 5) begin
        p[1] = 1'b0; p[0] = 1'b0; p[5] = 1'b0; p[3] = 1'b0;
      end else if (!(kind == 6 && kk == 7)) begin
        p[1] = ~b[3]; p[0] = ~b[2]; p[5] = 1'b0; p[3] = 1'b0;
      end
      p[2] = ~b[4]; p[6] = ~b[7];
    end
    return p;
  endfunction

  always_comb user_in = pad_pins(pad_kind, btn, k, user_out[4]);

  // ---------------- reference model ----------------
  // Result of one scan as {present, six_btn, joy}.
  function automatic logic [13:0] scan_result(int kind, logic [11:0] b);
    if (kind == 3) return {2'b10, 4'h0, b[7:0]};
    if (kind == 6) return {2'b11, b};
    return 14'h0;
  endfunction

  logic [13:0] model_q   = '0;
  logic [13:0] prev_tup  = '0;
  bit          prev_ok   = 1'b0;
  int          last_fall = -1;
  int          cyc       = 0;
  int          other_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if ((user_out | 7'h10) !== 7'h7F) other_bad <= other_bad + 1;

  task automatic set_pad(input int kind, input logic [11:0] b);
    pad_kind = kind;
    btn      = b;
  endtask

  task automatic random_pad();
    logic [11:0] b;
    int          r;
    b = 12'($urandom);
    if (b[3] && b[2]) b[2] = 1'b0;   // a d-pad cannot press Up and Down together
    r = int'($urandom_range(0, 5));
    set_pad((r == 0) ? 0 : (r < 3) ? 3 : 6, b);
  endtask

  task automatic wait_th_fall(input string tag, output bit ok);
    int n;
    n = 0;
    while (user_out[4] !== 1'b0 && n < 2 * POLL) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 2 * POLL);
    if (!ok) check({tag, "_th_timeout"}, 32'd1, 32'd0);
  endtask

  // Follow one scan from the first TH-low phase through the publish cycle.
  task automatic do_scan(input string tag);
    bit          ok, upd;
    int          th_err;
    logic [13:0] tup;
    logic        exp_th;
    wait_th_fall(tag, ok);
    if (!ok) return;
    if (last_fall >= 0) check({tag, "_spacing"}, 32'(cyc - last_fall), 32'(POLL));
    last_fall = cyc;
    th_err = 0;
    for (int i = 0; i < 7 * P; i++) begin
      exp_th = (((1 + i / P) % 2) == 0);
      if (user_out[4] !== exp_th || joy_valid !== 1'b0) th_err++;
      @(negedge clk);
    end
    check({tag, "_th_pattern_errs"}, 32'(th_err), 32'd0);
    check({tag, "_latch_th_valid"}, {30'd0, user_out[4], joy_valid}, 32'h2);
    tup = scan_result(pad_kind, btn);
`ifdef SEGA_PAD_FILTER_EN
    upd      = prev_ok && (tup == prev_tup);
    prev_tup = tup;
    prev_ok  = 1'b1;
`else
    upd = 1'b1;
`endif
    if (upd) model_q = tup;
    @(negedge clk);
    check({tag, "_valid"},   {31'd0, joy_valid}, {31'd0, upd});
    check({tag, "_joy"},     {20'd0, joy},       {20'd0, model_q[11:0]});
    check({tag, "_present"}, {31'd0, present},   {31'd0, model_q[13]});
    check({tag, "_six"},     {31'd0, six_btn},   {31'd0, model_q[12]});
    @(negedge clk);
    check({tag, "_valid_width"}, {31'd0, joy_valid}, 32'd0);
  endtask

  task automatic model_reset();
    model_q   = '0;
    prev_ok   = 1'b0;
    prev_tup  = '0;
    last_fall = -1;
  endtask

  initial begin
    bit ok;
    int seen;
    reset_n = 1'b0;
    set_pad(0, 12'h0);
    repeat (3) @(negedge clk);
    check("rst_user_out", {25'd0, user_out}, 32'h7F);
    check("rst_outputs", {17'd0, joy, joy_valid, present, six_btn}, 32'd0);
    reset_n = 1'b1;

    // Directed patterns (each run twice so a stability filter also publishes)
    set_pad(3, 12'h011);
    do_scan("t1_3btn_a_right");
    do_scan("t1_3btn_a_right_b");
    set_pad(6, 12'h880);
    do_scan("t2_6btn_z_start");
    do_scan("t2_6btn_z_start_b");
    set_pad(0, 12'hFFF);
    do_scan("t3_unplugged");
    do_scan("t3_unplugged_b");

    // Randomized pads, each held for one or two scans
    for (int i = 0; i < 10; i++) begin
      random_pad();
      do_scan("rand");
      if ($urandom_range(0, 1) == 1) do_scan("rand_hold");
    end

    // Reset in the middle of phase 3
    set_pad(6, 12'h0FF);
    wait_th_fall("t4", ok);
    if (ok) begin
      repeat (2 * P + 2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("t4_rst_user_out", {25'd0, user_out}, 32'h7F);
      check("t4_rst_outputs", {17'd0, joy, joy_valid, present, six_btn}, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      seen = 0;
      for (int i = 0; i < 150; i++) begin
        @(negedge clk);
        if (joy_valid === 1'b1) seen++;
      end
      check("t4_no_valid_after_rst", 32'(seen), 32'd0);
      set_pad(3, 12'h0A5);
      do_scan("t4_after_rst");
      do_scan("t4_after_rst_b");
    end

    // Toggling button every scan, then held stable
    for (int i = 0; i < 4; i++) begin
      set_pad(3, (i % 2 == 0) ? 12'h010 : 12'h020);
      do_scan("t6_toggle");
    end
    set_pad(3, 12'h040);
    do_scan("t6_stable_1");
    do_scan("t6_stable_2");

    check("other_lines_released_errs", 32'(other_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
